sc_reg_loadshift: RTL and testbench
===================================

SC_REG_LOADSHIFT -- requirements
Module: sc_reg_loadshift

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32: width of the data bus and the register.
REQ-002 Parameter DATA_REG_INIT, default 32'h00000000: register value after reset.
REQ-003 Port SC_RegLOADSHIFT_CLOCK_50, input, 1: clock; all state updates on the falling edge.
REQ-004 Port SC_RegFIXED_Reset_InHigh, input, 1: reset, asynchronous, active-high.
REQ-005 Port SC_RegLOADSHIFT_DataBUS_In, input, DATAWIDTH_BUS: bus value to capture.
REQ-006 Port SC_RegLOADSHIFT_Load_InLow, input, 1: capture request, active-low.
REQ-007 Port SC_RegLOADSHIFT_Start_InHigh, input, 1: start a shift operation.
REQ-008 Port SC_RegLOADSHIFT_ShiftDir_In, input, 1: 0 = shift left, 1 = shift right (logical).
REQ-009 Port SC_RegLOADSHIFT_ShiftAmount_In, input, log2(DATAWIDTH_BUS): number of 1-bit shifts.
REQ-010 Port SC_RegLOADSHIFT_DataBUS_Out, output, DATAWIDTH_BUS: current register contents.
REQ-011 Port SC_RegLOADSHIFT_Busy_Out, output, 1: high while state is not IDLE.
REQ-012 Port SC_RegLOADSHIFT_Done_Out, output, 1: high for exactly one cycle while state is DONE.
REQ-013 Port SC_RegLOADSHIFT_Zero_Out, output, 1: combinational, high when the register equals 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with Load_InLow=0, the register SHALL capture DataBUS_In on the next falling edge, and the state SHALL remain IDLE.
REQ-016 In IDLE with Load_InLow=1 and Start_InHigh=1, the falling edge SHALL latch ShiftAmount and ShiftDir; the state SHALL go to SHIFT, or to DONE if the amount is 0.
REQ-017 When Load_InLow=0 and Start_InHigh=1 in IDLE, Load SHALL win and Start SHALL be ignored.
REQ-018 In SHIFT, each falling edge SHALL shift the register by one bit in the latched direction, zero-filled, and decrement the counter; on count=1 the next state SHALL be DONE.
REQ-019 For a start sampled at edge k with amount N>0, shifts SHALL occur at edges k+1..k+N, DONE SHALL be entered at edge k+N, and IDLE at edge k+N+1.
REQ-020 In SHIFT and DONE, Load_InLow, Start_InHigh, ShiftDir and ShiftAmount SHALL be ignored; input changes SHALL NOT affect an operation in progress.
REQ-021 DONE SHALL always return to IDLE after one cycle and SHALL NOT modify the register.
REQ-022 Bits shifted out SHALL be discarded; no carry or overflow output exists.
REQ-023 DataBUS_Out SHALL be the register value directly, with no extra latency.

Reset
REQ-024 Assertion of SC_RegFIXED_Reset_InHigh SHALL immediately set register=DATA_REG_INIT, state=IDLE, counter=0, Busy_Out=0 and Done_Out=0, independent of the clock.
REQ-025 Reset during SHIFT SHALL abort the operation with no Done pulse.
REQ-026 After reset release, the first falling edge SHALL follow the IDLE rules.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the derived counter-width constant.
REQ-028 The shift counter SHALL be a sub-module, sc_shiftcounter: a down-counter with load, decrement, count=1 flag and async reset.
REQ-029 Next-state, output and register logic SHALL be separated into combinational and sequential processes.

Verification
REQ-030 Reset with DATA_REG_INIT=32'hA5A5A5A5 -> DataBUS_Out=A5A5A5A5, Busy=0, Done=0, Zero=0.
REQ-031 Load 32'h0000000F, then Start left by 4 -> DataBUS_Out=000000F0 after edge k+4, Done high one cycle, Busy high 5 cycles.
REQ-032 Load 32'h80000001, then Start right by 31 -> final value 00000001, Done at edge k+31.
REQ-033 Start with amount 0 -> no value change, Done high the following cycle, Busy high 1 cycle.
REQ-034 Load 32'h12345678 and Start asserted together -> register=12345678, state stays IDLE, Busy=0.
REQ-035 Reset asserted mid-SHIFT (left by 8 on 32'h1) after 3 shifts -> DataBUS_Out=DATA_REG_INIT asynchronously, no Done pulse; Load during SHIFT -> ignored.

Source files
------------

// File: rtl/sc_reg_loadshift_pkg.sv
// Shared definitions for the load/shift register: FSM state encoding and counter sizing.
package sc_reg_loadshift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Shift-amount / counter width for a given data width; never narrower than one bit.
  function automatic int sc_cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int SC_DATAWIDTH_DEF = 32;
  localparam int SC_CNT_W_DEF     = sc_cnt_width(SC_DATAWIDTH_DEF);

endpackage

// File: rtl/sc_shiftcounter.sv
// Down-counter tracking remaining 1-bit shifts; flags when the last shift is due.
module sc_shiftcounter #(
  parameter int CW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [CW-1:0] load_val_i,
  output logic          one_o
);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign one_o = (count_q == CW'(1));

endmodule

// File: rtl/sc_reg_loadshift.sv
// Loadable register with a multi-cycle logical shifter, sequenced by an IDLE/SHIFT/DONE FSM.
module sc_reg_loadshift
  import sc_reg_loadshift_pkg::*;
#(
  parameter int                     DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REG_INIT = 32'h00000000
) (
  input  logic                                   SC_RegLOADSHIFT_CLOCK_50,
  input  logic                                   SC_RegFIXED_Reset_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               SC_RegLOADSHIFT_DataBUS_In,
  input  logic                                   SC_RegLOADSHIFT_Load_InLow,
  input  logic                                   SC_RegLOADSHIFT_Start_InHigh,
  input  logic                                   SC_RegLOADSHIFT_ShiftDir_In,
  input  logic [sc_cnt_width(DATAWIDTH_BUS)-1:0] SC_RegLOADSHIFT_ShiftAmount_In,
  output logic [DATAWIDTH_BUS-1:0]               SC_RegLOADSHIFT_DataBUS_Out,
  output logic                                   SC_RegLOADSHIFT_Busy_Out,
  output logic                                   SC_RegLOADSHIFT_Done_Out,
  output logic                                   SC_RegLOADSHIFT_Zero_Out,
  output state_t                                 dbg_state_o
);

  localparam int CW = sc_cnt_width(DATAWIDTH_BUS);

  state_t                   state_d, state_q;
  logic [DATAWIDTH_BUS-1:0] data_d, data_q;
  logic                     dir_d, dir_q;
  logic                     cnt_load, cnt_dec, cnt_one;

  sc_shiftcounter #(.CW(CW)) u_cnt (
    .clk_i      (SC_RegLOADSHIFT_CLOCK_50),
    .rst_i      (SC_RegFIXED_Reset_InHigh),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (SC_RegLOADSHIFT_ShiftAmount_In),
    .one_o      (cnt_one)
  );

  // Load has priority over Start in IDLE; all inputs are ignored while an operation runs.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!SC_RegLOADSHIFT_Load_InLow) begin
          data_d = SC_RegLOADSHIFT_DataBUS_In;
        end else if (SC_RegLOADSHIFT_Start_InHigh) begin
          dir_d    = SC_RegLOADSHIFT_ShiftDir_In;
          cnt_load = 1'b1;
          state_d  = (SC_RegLOADSHIFT_ShiftAmount_In == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d  = dir_q ? (data_q >> 1) : (data_q << 1);
        cnt_dec = 1'b1;
        if (cnt_one) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge SC_RegLOADSHIFT_CLOCK_50 or posedge SC_RegFIXED_Reset_InHigh) begin
    if (SC_RegFIXED_Reset_InHigh) begin
      state_q <= ST_IDLE;
      data_q  <= DATA_REG_INIT;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

  assign SC_RegLOADSHIFT_DataBUS_Out = data_q;
  assign SC_RegLOADSHIFT_Busy_Out    = (state_q != ST_IDLE);
  assign SC_RegLOADSHIFT_Done_Out    = (state_q == ST_DONE);
  assign SC_RegLOADSHIFT_Zero_Out    = (data_q == '0);
  assign dbg_state_o                 = state_q;

endmodule

// File: tb/tb_sc_reg_loadshift.sv
// Self-checking bench for sc_reg_loadshift: directed table, corner sequences, randomized run vs. model.
module tb_sc_reg_loadshift;
  import sc_reg_loadshift_pkg::*;

  localparam int            W    = 32;
  localparam int            AW   = 5;
  localparam logic [W-1:0]  INIT = 32'hA5A5A5A5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          load_n, start, dir;
  logic [AW-1:0] amt;
  logic [W-1:0]  dout;
  logic          busy, done, zero;
  state_t        dbg_state;

  always #10 clk = ~clk;

  sc_reg_loadshift #(.DATAWIDTH_BUS(W), .DATA_REG_INIT(INIT)) dut (
    .SC_RegLOADSHIFT_CLOCK_50       (clk),
    .SC_RegFIXED_Reset_InHigh       (rst),
    .SC_RegLOADSHIFT_DataBUS_In     (din),
    .SC_RegLOADSHIFT_Load_InLow     (load_n),
    .SC_RegLOADSHIFT_Start_InHigh   (start),
    .SC_RegLOADSHIFT_ShiftDir_In    (dir),
    .SC_RegLOADSHIFT_ShiftAmount_In (amt),
    .SC_RegLOADSHIFT_DataBUS_Out    (dout),
    .SC_RegLOADSHIFT_Busy_Out       (busy),
    .SC_RegLOADSHIFT_Done_Out       (done),
    .SC_RegLOADSHIFT_Zero_Out       (zero),
    .dbg_state_o                    (dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- scoreboard / model ----------------
  // Each entry is {busy, done, data} expected after one falling edge.
  logic [W+1:0] exp_q[$];
  logic [W-1:0] m_reg;

  function automatic logic [W-1:0] shift_by(input logic [W-1:0] v, input logic d, input int n);
    return d ? (v >> n) : (v << n);
  endfunction

  task automatic model_edge(input logic ln, input logic st, input logic d, input logic [AW-1:0] a,
                            input logic [W-1:0] di, output logic [W+1:0] e);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
    end else if (!ln) begin
      m_reg = di;
      e = {2'b00, m_reg};
    end else if (st) begin
      e = {1'b1, (a == '0), m_reg};
      for (int i = 1; i <= int'(a); i++)
        exp_q.push_back({1'b1, (i == int'(a)), shift_by(m_reg, d, i)});
      m_reg = shift_by(m_reg, d, int'(a));
      exp_q.push_back({2'b00, m_reg});
    end else begin
      e = {2'b00, m_reg};
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] e_data, input logic e_busy, input logic e_done);
    n_vec++;
    if (dout !== e_data || busy !== e_busy || done !== e_done || zero !== (e_data == '0)) begin
      n_bad++;
      $display("FAIL %s: got data=%h busy=%b done=%b zero=%b, want data=%h busy=%b done=%b zero=%b",
               name, dout, busy, done, zero, e_data, e_busy, e_done, (e_data == '0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ln, input logic st, input logic d, input logic [AW-1:0] a, input logic [W-1:0] di);
    load_n = ln; start = st; dir = d; amt = a; din = di;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_n = 1'b1; start = 1'b0; dir = 1'b0; amt = '0; din = '0;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    m_reg = INIT;
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          load_n;
    logic          start;
    logic          dir;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic [W-1:0]  e_data;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [W+1:0] e;
    logic         r_ln, r_st, r_dir;
    logic [AW-1:0] r_amt;
    logic [W-1:0] r_din;
    bit           saw_done;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0000000F, 32'h0000000F, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'd4,  32'hDEADBEEF, 32'h0000000F, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'd9,  32'h00000000, 32'h0000001E, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h0000003C, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 5'd2,  32'h00000000, 32'h00000078, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h000000F0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h000000F0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 5'd0,  32'h11111111, 32'h000000F0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h000000F0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 5'd4,  32'h12345678, 32'h12345678, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h12345678, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 5'd1,  32'hCAFEF00D, 32'h12345678, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 5'd7,  32'hFFFFFFFF, 32'h091A2B3C, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h091A2B3C, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 1'b1, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h00000000, 32'h00000000, 1'b0, 1'b0};

    do_reset();
    @(posedge clk);
    check("reset_state", INIT, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].load_n, tbl[i].start, tbl[i].dir, tbl[i].amt, tbl[i].din);
      check($sformatf("table[%0d]", i), tbl[i].e_data, tbl[i].e_busy, tbl[i].e_done);
    end

    // Right shift by the maximum amount.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h80000001);
    check("max_load", 32'h80000001, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 5'd31, 32'h0);
    check("max_start", 32'h80000001, 1'b1, 1'b0);
    for (int i = 1; i <= 31; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check($sformatf("max_shift[%0d]", i), (32'h80000001 >> i), 1'b1, (i == 31));
    end
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check("max_idle", 32'h00000001, 1'b0, 1'b0);

    // Reset in the middle of a shift, with a Load attempt while shifting.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h00000001);
    drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h0);
    check("abort_start", 32'h00000001, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd2, 32'h55555555);
      check($sformatf("abort_shift[%0d]", i), (32'h00000001 << i), 1'b1, 1'b0);
    end
    #4 rst = 1'b1;
    #1 check("abort_async", INIT, 1'b0, 1'b0);
    load_n = 1'b1; start = 1'b0;
    @(negedge clk);
    #1 check("abort_hold", INIT, 1'b0, 1'b0);
    #4 rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      if (done) saw_done = 1'b1;
    end
    check("abort_after", INIT, 1'b0, 1'b0);
    n_vec++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL abort_no_done: got done pulse=1, want 0");
    end
    drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h0BADF00D);
    check("post_reset_load", 32'h0BADF00D, 1'b0, 1'b0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r_ln  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      r_st  = $urandom_range(0, 1);
      r_dir = $urandom_range(0, 1);
      r_amt = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
      r_din = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model_edge(r_ln, r_st, r_dir, r_amt, r_din, e);
      drive(r_ln, r_st, r_dir, r_amt, r_din);
      check($sformatf("rand[%0d]", i), e[W-1:0], e[W+1], e[W]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
